char_move_ctrl: RTL and testbench

CHAR_MOVE_CTRL -- requirements
Module: char_move_ctrl

---
 rtl/game_pkg.sv | 34 +++
 rtl/step_timer.sv | 29 ++
 rtl/char_move_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_char_move_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the character movement block: FSM state
// encoding, default screen size, counter width and sprite_control layout.
package game_pkg;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;
  localparam int CNT_W    = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    JUMPING = 2'd2,
    FALLING = 2'd3
  } move_state_t;

  // sprite_control = {dir, air, idle, frame[3:0]}
  localparam int SC_DIR       = 6;
  localparam int SC_AIR       = 5;
  localparam int SC_IDLE      = 4;
  localparam int SC_FRAME_MSB = 3;
  localparam int SC_FRAME_LSB = 0;

  function automatic logic [6:0] pack_sprite(input logic dir, input logic air,
                                              input logic idle, input logic [3:0] frame);
    logic [6:0] s;
    s = '0;
    s[SC_DIR] = dir;
    s[SC_AIR] = air;
    s[SC_IDLE] = idle;
    s[SC_FRAME_MSB:SC_FRAME_LSB] = frame;
    return s;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step divider: counts up every enabled cycle and issues a
// single-cycle step when the count reaches div, so steps are div+1 apart.
// clr restarts the count and suppresses a step in the same cycle.
module step_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             step
);

  logic [WIDTH-1:0] cnt;

  assign step = en && !clr && (cnt >= div);

  // Counter: hold when disabled, restart on clear or on a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (clr || step) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/char_move_ctrl.sv
// Platformer character movement: walk, variable-height jump with multi-jump,
// accelerating fall. Collision comes in from outside via ground_below and
// ceiling_above; positions are the registered top-left corner.
module char_move_ctrl #(
  parameter int SPAWN_X      = 500,
  parameter int CHAR_W       = 64,
  parameter int CHAR_H       = 64,
  parameter int SCREEN_W     = game_pkg::SCREEN_W,
  parameter int SCREEN_H     = game_pkg::SCREEN_H,
  parameter int SPAWN_Y      = SCREEN_H - 1 - CHAR_H,
  parameter int WALK_DIV     = 350_000,
  parameter int AIR_DIV      = 650_000,
  parameter int JUMP_HEIGHT  = 200,
  parameter int JUMP_DIV0    = 200_000,
  parameter int JUMP_DIV_MAX = 800_000,
  parameter int FALL_DIV0    = 800_000,
  parameter int FALL_DIV_MIN = 150_000,
  parameter int DIV_STEP     = 20_000,
  parameter int MAX_JUMPS    = 2,
  parameter int ANIM_FRAMES  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  respawn,
  input  logic                  over,
  input  logic                  left,
  input  logic                  right,
  input  logic                  jump,
  input  logic                  ground_below,
  input  logic                  ceiling_above,
  output logic [6:0]            sprite_control,
  output logic [9:0]            x,
  output logic [9:0]            y,
  output game_pkg::move_state_t state_dbg,
  output logic [1:0]            jumps_used_dbg
);

  import game_pkg::*;

  localparam logic [9:0]       FLOOR_C   = 10'(SCREEN_H - 1 - CHAR_H);
  localparam logic [9:0]       X_MAX_C   = 10'(SCREEN_W - CHAR_W);
  localparam logic [9:0]       SPAWN_X_C = 10'(SPAWN_X);
  localparam logic [9:0]       SPAWN_Y_C = 10'(SPAWN_Y);
  localparam logic [9:0]       JH_C      = 10'(JUMP_HEIGHT);
  localparam logic [9:0]       JH_SLOW_C = 10'(JUMP_HEIGHT - 25);
  localparam logic [1:0]       MAXJ_C    = 2'(MAX_JUMPS);
  localparam logic [3:0]       FR_LAST_C = 4'(ANIM_FRAMES - 1);
  localparam logic [CNT_W-1:0] WALK_C    = CNT_W'(WALK_DIV);
  localparam logic [CNT_W-1:0] AIR_C     = CNT_W'(AIR_DIV);
  localparam logic [CNT_W-1:0] JD0_C     = CNT_W'(JUMP_DIV0);
  localparam logic [CNT_W-1:0] JDMAX_C   = CNT_W'(JUMP_DIV_MAX);
  localparam logic [CNT_W-1:0] FD0_C     = CNT_W'(FALL_DIV0);
  localparam logic [CNT_W-1:0] FDMIN_C   = CNT_W'(FALL_DIV_MIN);
  localparam logic [CNT_W-1:0] DS_C      = CNT_W'(DIV_STEP);

  move_state_t      state, state_n;
  logic [9:0]       x_n, y_n, y_start, y_start_n, rise, x_move;
  logic             dir, dir_n, jump_d;
  logic [3:0]       frame, frame_n;
  logic [1:0]       jumps_used, jumps_n;
  logic [CNT_W-1:0] jump_div, jump_div_n, fall_div, fall_div_n, x_div, y_div;
  logic [6:0]       sprite_n;
  logic             grounded, jump_rise, dir_valid, dir_chg, t_clr, x_step, y_step;
  logic             air_n, idle_n;

  assign grounded  = ground_below || (y == FLOOR_C);
  assign jump_rise = jump && !jump_d;
  assign dir_valid = left ^ right;
  assign dir_chg   = dir_valid && (right != dir);
  assign rise      = y_start - y;
  assign x_move    = right ? ((x >= X_MAX_C) ? X_MAX_C : x + 10'd1)
                           : ((x == 10'd0)   ? 10'd0   : x - 10'd1);

  // Timers restart whenever the state or facing direction changes.
  assign t_clr = respawn || (state_n != state) || dir_chg;
  assign x_div = ((state == JUMPING) || (state == FALLING)) ? AIR_C : WALK_C;
  assign y_div = (state == JUMPING) ? jump_div : fall_div;

  step_timer #(.WIDTH(CNT_W)) u_x_timer (
    .clk(clk), .rst(rst), .en(!over), .clr(t_clr), .div(x_div), .step(x_step)
  );

  step_timer #(.WIDTH(CNT_W)) u_y_timer (
    .clk(clk), .rst(rst), .en(!over), .clr(t_clr), .div(y_div), .step(y_step)
  );

  // Next-state selection; respawn overrides, unknown encodings fall back to IDLE.
  always_comb begin
    state_n = state;
    if (respawn) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!grounded)      state_n = FALLING;
          else if (jump_rise) state_n = JUMPING;
          else if (dir_valid) state_n = MOVING;
        end
        MOVING: begin
          if (!dir_valid)     state_n = IDLE;
          else if (jump_rise) state_n = JUMPING;
          else if (!grounded) state_n = FALLING;
        end
        JUMPING: begin
          if ((rise >= JH_C) || ceiling_above || (y == 10'd0) || !jump)
            state_n = FALLING;
        end
        FALLING: begin
          if (grounded)                                state_n = IDLE;
          else if (jump_rise && (jumps_used < MAXJ_C)) state_n = JUMPING;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Datapath: position, animation, jump bookkeeping and divisor ramps.
  always_comb begin
    x_n        = x;
    y_n        = y;
    dir_n      = dir_valid ? right : dir;
    frame_n    = frame;
    jumps_n    = jumps_used;
    y_start_n  = y_start;
    jump_div_n = jump_div;
    fall_div_n = fall_div;
    if (respawn) begin
      x_n       = SPAWN_X_C;
      y_n       = SPAWN_Y_C;
      dir_n     = 1'b1;
      frame_n   = 4'd0;
      jumps_n   = 2'd0;
      y_start_n = 10'd0;
    end else begin
      case (state)
        IDLE: ;
        MOVING: begin
          if (x_step) begin
            x_n = x_move;
            if (x[2:0] == 3'd0) frame_n = (frame >= FR_LAST_C) ? 4'd0 : frame + 4'd1;
          end
        end
        JUMPING, FALLING: begin
          if (x_step && dir_valid) x_n = x_move;
        end
        default: begin
          dir_n   = 1'b1;
          frame_n = 4'd0;
          jumps_n = 2'd0;
        end
      endcase
      // Launching a jump takes the first pixel of rise immediately.
      if ((state_n == JUMPING) && (state != JUMPING)) begin
        y_start_n  = y;
        jump_div_n = JD0_C;
        jumps_n    = jumps_used + 2'd1;
        y_n        = (y == 10'd0) ? 10'd0 : y - 10'd1;
      end else if ((state_n == FALLING) && (state != FALLING)) begin
        fall_div_n = FD0_C;
      end else if ((state == JUMPING) && y_step) begin
        y_n = (y == 10'd0) ? 10'd0 : y - 10'd1;
        if (rise >= JH_SLOW_C)
          jump_div_n = (jump_div >= JDMAX_C - DS_C) ? JDMAX_C : jump_div + DS_C;
      end else if ((state == FALLING) && y_step) begin
        y_n        = (y >= FLOOR_C) ? FLOOR_C : y + 10'd1;
        fall_div_n = (fall_div <= FDMIN_C + DS_C) ? FDMIN_C : fall_div - DS_C;
      end
      if ((state == FALLING) && (state_n == IDLE)) jumps_n = 2'd0;
    end
  end

  assign air_n    = (state_n == JUMPING) || (state_n == FALLING);
  assign idle_n   = (state_n == IDLE);
  assign sprite_n = pack_sprite(dir_n, air_n, idle_n, idle_n ? 4'd0 : frame_n);

  // State and datapath registers; game over freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      x              <= SPAWN_X_C;
      y              <= SPAWN_Y_C;
      dir            <= 1'b0;
      frame          <= 4'd0;
      jumps_used     <= 2'd0;
      jump_d         <= 1'b0;
      y_start        <= 10'd0;
      jump_div       <= '0;
      fall_div       <= '0;
      sprite_control <= 7'd0;
    end else if (!over) begin
      state          <= state_n;
      x              <= x_n;
      y              <= y_n;
      dir            <= dir_n;
      frame          <= frame_n;
      jumps_used     <= jumps_n;
      jump_d         <= jump;
      y_start        <= y_start_n;
      jump_div       <= jump_div_n;
      fall_div       <= fall_div_n;
      sprite_control <= sprite_n;
    end
  end

  assign state_dbg      = state;
  assign jumps_used_dbg = jumps_used;

endmodule

// File: tb/tb_char_move_ctrl.sv
// Directed bench for char_move_ctrl using short dividers so walks, jumps and
// falls complete in a few hundred cycles. Expected values are hand-derived.
module tb_char_move_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst, respawn, over, left, right, jump, ground_below, ceiling_above;
  logic [6:0]  sprite_control;
  logic [9:0]  x, y;
  move_state_t state_dbg;
  logic [1:0]  jumps_used_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] min_y;

  char_move_ctrl #(
    .WALK_DIV(3), .AIR_DIV(5), .JUMP_HEIGHT(30), .JUMP_DIV0(2), .FALL_DIV0(6),
    .FALL_DIV_MIN(2), .DIV_STEP(1), .SCREEN_H(768), .CHAR_H(64)
  ) dut (
    .clk(clk), .rst(rst), .respawn(respawn), .over(over), .left(left),
    .right(right), .jump(jump), .ground_below(ground_below),
    .ceiling_above(ceiling_above), .sprite_control(sprite_control),
    .x(x), .y(y), .state_dbg(state_dbg), .jumps_used_dbg(jumps_used_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance n cycles; sample 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (y < min_y) min_y = y;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_state(input move_state_t s, input int budget);
    for (int i = 0; i < budget && state_dbg != s; i++) tick(1);
  endtask

  task automatic wait_y(input logic [9:0] t, input int budget);
    for (int i = 0; i < budget && y != t; i++) tick(1);
  endtask

  task automatic wait_x(input logic [9:0] t, input int budget);
    for (int i = 0; i < budget && x != t; i++) tick(1);
  endtask

  initial begin
    rst = 1'b1; respawn = 1'b0; over = 1'b0; left = 1'b0; right = 1'b0;
    jump = 1'b0; ground_below = 1'b0; ceiling_above = 1'b0;
    min_y = 10'd1023;
    tick(3);
    rst = 1'b0;
    check_eq("reset_x", 32'(x), 32'd500);
    check_eq("reset_y", 32'(y), 32'd703);
    check_eq("reset_sprite", 32'(sprite_control), 32'd0);
    check_eq("reset_state", 32'(state_dbg), 32'(IDLE));

    // Walk right: one cycle to enter MOVING, then 10 steps of 4 cycles.
    right = 1'b1;
    tick(41);
    check_eq("walk_x", 32'(x), 32'd510);
    check_eq("walk_state", 32'(state_dbg), 32'(MOVING));
    check_eq("walk_sprite", 32'(sprite_control), 32'b1000001);
    right = 1'b0;
    tick(1);
    check_eq("walk_stop_state", 32'(state_dbg), 32'(IDLE));
    check_eq("walk_stop_sprite", 32'(sprite_control), 32'b1010000);

    // One-cycle jump pulse: one pixel of rise, then fall back and land.
    jump = 1'b1;
    tick(1);
    check_eq("pulse_state", 32'(state_dbg), 32'(JUMPING));
    check_eq("pulse_y", 32'(y), 32'd702);
    check_eq("pulse_sprite", 32'(sprite_control), 32'b1100001);
    jump = 1'b0;
    tick(1);
    check_eq("pulse_fall", 32'(state_dbg), 32'(FALLING));
    wait_state(IDLE, 100);
    check_eq("pulse_land_state", 32'(state_dbg), 32'(IDLE));
    check_eq("pulse_land_y", 32'(y), 32'd703);
    check_eq("pulse_land_jumps", 32'(jumps_used_dbg), 32'd0);

    // Held jump to full height, then double jump, then refused third jump.
    min_y = 10'd1023;
    jump = 1'b1;
    wait_state(FALLING, 2000);
    check_eq("full_fall", 32'(state_dbg), 32'(FALLING));
    check_eq("full_peak", 32'(min_y), 32'd673);
    jump = 1'b0;
    tick(1);
    jump = 1'b1;
    tick(1);
    check_eq("dbl_state", 32'(state_dbg), 32'(JUMPING));
    check_eq("dbl_jumps", 32'(jumps_used_dbg), 32'd2);
    jump = 1'b0;
    tick(1);
    check_eq("dbl_release", 32'(state_dbg), 32'(FALLING));
    jump = 1'b1;
    tick(1);
    check_eq("third_state", 32'(state_dbg), 32'(FALLING));
    check_eq("third_jumps", 32'(jumps_used_dbg), 32'd2);
    jump = 1'b0;
    wait_state(IDLE, 2000);
    check_eq("dbl_land_y", 32'(y), 32'd703);
    check_eq("dbl_land_jumps", 32'(jumps_used_dbg), 32'd0);

    // Ceiling hit at y=690 ends the rise immediately.
    jump = 1'b1;
    wait_y(10'd690, 2000);
    check_eq("ceil_reach_y", 32'(y), 32'd690);
    ceiling_above = 1'b1;
    tick(1);
    check_eq("ceil_state", 32'(state_dbg), 32'(FALLING));
    check_eq("ceil_y", 32'(y), 32'd690);
    ceiling_above = 1'b0;
    jump = 1'b0;
    min_y = 10'd1023;
    wait_state(IDLE, 2000);
    check_eq("ceil_min_y", 32'(min_y), 32'd690);
    check_eq("ceil_land_y", 32'(y), 32'd703);

    // Game over mid-jump freezes; inputs toggled meanwhile are ignored.
    jump = 1'b1;
    wait_y(10'd695, 2000);
    check_eq("over_reach_y", 32'(y), 32'd695);
    over = 1'b1; jump = 1'b0; left = 1'b1; ceiling_above = 1'b1;
    tick(100);
    check_eq("over_x", 32'(x), 32'd510);
    check_eq("over_y", 32'(y), 32'd695);
    check_eq("over_state", 32'(state_dbg), 32'(JUMPING));
    check_eq("over_sprite", 32'(sprite_control), 32'b1100001);
    over = 1'b0; jump = 1'b1; left = 1'b0; ceiling_above = 1'b0;
    tick(1);
    check_eq("over_resume", 32'(state_dbg), 32'(JUMPING));
    rst = 1'b1;
    tick(1);
    rst = 1'b0; jump = 1'b0;
    check_eq("midjump_rst_x", 32'(x), 32'd500);
    check_eq("midjump_rst_y", 32'(y), 32'd703);
    check_eq("midjump_rst_sprite", 32'(sprite_control), 32'd0);
    check_eq("midjump_rst_state", 32'(state_dbg), 32'(IDLE));
    check_eq("midjump_rst_jumps", 32'(jumps_used_dbg), 32'd0);

    // Walk into the left edge, then respawn.
    left = 1'b1;
    wait_x(10'd0, 2500);
    tick(20);
    check_eq("left_clamp_x", 32'(x), 32'd0);
    check_eq("left_clamp_state", 32'(state_dbg), 32'(MOVING));
    left = 1'b0;
    respawn = 1'b1;
    tick(1);
    respawn = 1'b0;
    check_eq("respawn_x", 32'(x), 32'd500);
    check_eq("respawn_y", 32'(y), 32'd703);
    check_eq("respawn_sprite", 32'(sprite_control), 32'b1010000);
    check_eq("respawn_state", 32'(state_dbg), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
